code_loader: RTL and testbench
==============================

Name: code_loader

Overview:
- Byte-serial program loader. Receives a length-prefixed program image over a valid/ready byte stream and assembles the flat 2048-bit code vector that the computer consumes.
- Holds the computer in reset until the image is complete, then releases it.
- Sits between an external host or stimulus source and the computer's code/reset inputs. It is the producer end of the code bus, replacing hard-wired images.

Parameters:
- BYTES, 256, image depth in bytes; code width = 8*BYTES.
- CW, 9, byte-count width; must satisfy 2^CW > BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: clear the image and begin a new load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- code  output  8*BYTES  assembled image; byte k occupies code[8k+7:8k].
- cpu_reset  output  1  active-low reset to the computer; low while not DONE.
- busy  output  1  high in LEN or DATA.
- done  output  1  high in DONE.
- count  output  CW  data bytes stored so far in the current load.

Behaviour:
- Transfer rule: a byte transfers on a rising edge when in_valid && in_ready. There is no other side effect of in_valid.
- Async reset (reset=0):
  - state=IDLE, code=0, count=0, len=0.
  - in_ready=0, busy=0, done=0, cpu_reset=0.
- States: IDLE, LEN, DATA, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> LEN, code cleared to 0, count=0.
- LEN:
  - in_ready=1.
  - On transfer, latch len = in_data, where 0 encodes BYTES.
  - Values > BYTES are impossible for BYTES=256. For a smaller BYTES, clamp len to BYTES.
  - -> DATA.
- DATA:
  - in_ready=1.
  - On transfer, code[8*count +: 8] <= in_data and count <= count+1.
  - When the accepted byte makes count == len -> DONE on that same edge.
- DONE:
  - in_ready=0, done=1, cpu_reset=1 (registered; goes high the cycle after the final byte's edge).
  - code holds stable.
  - start=1 -> LEN: image cleared, count=0, cpu_reset falls the next cycle.
- start in LEN/DATA: abort and restart. Clear code and count, go to LEN; the byte on that edge is discarded. start has priority over the transfer.
- Unwritten bytes beyond len stay 0 (NOP/zero fill).
- Latency: load of N data bytes at full throughput = N+1 transfers. done asserts 1 cycle after the last transfer edge (registered state).
- in_valid deasserted mid-load: the loader waits indefinitely, with no timeout.
- Reset mid-load: immediate return to IDLE with code cleared. cpu_reset stays 0.
- All outputs are registered or decoded from the registered state only. There is no combinational path from in_valid to in_ready.

Decomposition:
- Shared package/defines file, alongside the other primitive includes, holds:
  - state encodings LD_IDLE=2'd0, LD_LEN=2'd1, LD_DATA=2'd2, LD_DONE=2'd3;
  - CODE_BYTES=256.
- One sub-module is natural: byte_lane_reg, an 8-bit register with async active-low reset, synchronous clear and enable, instantiated BYTES times with enable = transfer && state==DATA && count==k.
- The FSM and counter stay in code_loader.

Test Plan:
- Reset then idle: reset=0 for 1 ns, release, no start -> code==0, cpu_reset=0, in_ready=0, done=0 for 10 cycles.
- Basic load: start; stream 8'h03, 8'h01, 8'h01, 8'h44 with in_valid held -> code[23:0]==24'h440101, rest zero, count==3. done and cpu_reset rise 1 cycle after the 4th transfer.
- Back-pressure/gaps: same 4 bytes with in_valid toggled 1,0,0,1,1,0,1 -> identical final code. Transfers occur only on cycles with in_valid=1.
- Full image: start; len 8'h00 then 256 bytes with value k^8'hA5 -> code[8k+7:8k]==k^8'hA5 for all k, count==256, done=1.
- Abort: start; len 8'h05, 2 bytes, then start coincident with a valid byte -> that byte is dropped, code==0, state LEN. A subsequent 8'h01, 8'h7E load gives code[7:0]==8'h7E.
- Reset mid-load and reload after DONE: reset=0 during DATA -> all outputs at reset values. From DONE, start -> cpu_reset falls the next cycle and code clears.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared definitions for the byte-serial program loader: loader state
// encodings, default image depth and the length-byte decode helper.
package code_loader_pkg;

    localparam int CODE_BYTES = 256;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LEN  = 2'd1,
        LD_DATA = 2'd2,
        LD_DONE = 2'd3
    } ld_state_e;

    // Convert the length-prefix byte into a byte count: 0 means a full
    // image, and anything larger than the image depth is clamped to it.
    function automatic int unsigned decode_len(input logic [7:0] len_byte,
                                               input int unsigned depth);
        int unsigned value;
        value = {24'd0, len_byte};
        if (len_byte == 8'd0) begin
            decode_len = depth;
        end else if (value > depth) begin
            decode_len = depth;
        end else begin
            decode_len = value;
        end
    endfunction

endpackage

// File: rtl/code_loader_byte_lane_reg.sv
// One byte of the code image: async active-low reset, synchronous clear
// (which wins over the write enable) and a write enable.
module byte_lane_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] d_i,
    output logic [7:0] q_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next value: clear first, then write, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 8'd0;
        end else if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // Byte storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 8'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/code_loader.sv
// Byte-serial program loader. Accepts a length byte followed by that many
// data bytes over a valid/ready stream, assembles them into the flat code
// vector and holds the computer in reset until the image is complete.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int BYTES = CODE_BYTES,
    parameter int CW    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*BYTES-1:0] code,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      count
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    ld_state_e          state_q;
    ld_state_e          state_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      len_q;
    logic [CW-1:0]      len_d;
    logic [CW-1:0]      count_inc_s;
    logic               ready_s;
    logic               xfer_s;
    logic               data_wr_s;
    logic [BYTES-1:0]   lane_we_s;

    // Handshake is decoded from the registered state only, so in_ready
    // never depends on in_valid.
    assign ready_s     = (state_q == LD_LEN) || (state_q == LD_DATA);
    assign xfer_s      = in_valid && ready_s;
    assign data_wr_s   = xfer_s && (state_q == LD_DATA);
    assign count_inc_s = count_q + CNT_ONE;

    // Next-state, byte counter and length latch; start beats any transfer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d = LD_LEN;
                    count_d = '0;
                    len_d   = '0;
                end else begin
                    state_d = LD_IDLE;
                end
            end
            LD_LEN: begin
                if (start) begin
                    state_d = LD_LEN;
                    count_d = '0;
                    len_d   = '0;
                end else if (xfer_s) begin
                    len_d   = CW'(decode_len(in_data, BYTES));
                    state_d = LD_DATA;
                end else begin
                    state_d = LD_LEN;
                end
            end
            LD_DATA: begin
                if (start) begin
                    state_d = LD_LEN;
                    count_d = '0;
                    len_d   = '0;
                end else if (xfer_s) begin
                    count_d = count_inc_s;
                    if (count_inc_s == len_q) begin
                        state_d = LD_DONE;
                    end else begin
                        state_d = LD_DATA;
                    end
                end else begin
                    state_d = LD_DATA;
                end
            end
            LD_DONE: begin
                if (start) begin
                    state_d = LD_LEN;
                    count_d = '0;
                    len_d   = '0;
                end else begin
                    state_d = LD_DONE;
                end
            end
            default: begin
                state_d = LD_IDLE;
                count_d = '0;
                len_d   = '0;
            end
        endcase
    end

    // FSM state, counter and length registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LD_IDLE;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // One byte lane per image byte; the lane selected by the current count
    // captures the accepted data byte, and start wipes every lane.
    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        assign lane_we_s[k] = data_wr_s && (count_q == CW'(k));

        byte_lane_reg u_lane (
            .clk   (clk),
            .rst_n (reset),
            .clr_i (start),
            .en_i  (lane_we_s[k]),
            .d_i   (in_data),
            .q_o   (code[8*k +: 8])
        );
    end

    assign in_ready  = ready_s;
    assign busy      = ready_s;
    assign done      = (state_q == LD_DONE);
    assign cpu_reset = (state_q == LD_DONE);
    assign count     = count_q;

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: table-driven vectors for the basic and gapped
// loads, hand sequences for full image, abort, reset and reload, and a
// randomized run against a queue-based reference model.
module tb_code_loader;

    localparam int BYTES = 256;
    localparam int CW    = 9;

    logic               clk;
    logic               reset;
    logic               start;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [8*BYTES-1:0] code;
    logic               cpu_reset;
    logic               busy;
    logic               done;
    logic [CW-1:0]      count;

    int tests;
    int fails;

    code_loader #(.BYTES(BYTES), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A load is "open" after start; the first accepted byte is the target
    // length, the following bytes are appended to the image queue.
    bit         m_open;
    bit         m_have_len;
    bit         m_loaded;
    int         m_target;
    logic [7:0] m_img[$];

    task automatic model_reset();
        m_open     = 1'b0;
        m_have_len = 1'b0;
        m_loaded   = 1'b0;
        m_target   = 0;
        m_img.delete();
    endtask

    task automatic model_edge(input logic st, input logic v, input logic [7:0] d);
        if (st) begin
            m_open     = 1'b1;
            m_have_len = 1'b0;
            m_loaded   = 1'b0;
            m_img.delete();
        end else if (m_open && v) begin
            if (!m_have_len) begin
                m_target   = (d == 8'd0) ? BYTES : int'(d);
                m_have_len = 1'b1;
            end else begin
                m_img.push_back(d);
                if (m_img.size() == m_target) begin
                    m_open   = 1'b0;
                    m_loaded = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [8*BYTES-1:0] model_code();
        logic [8*BYTES-1:0] v;
        v = '0;
        for (int i = 0; i < m_img.size(); i++) v[8*i +: 8] = m_img[i];
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic step(input logic st, input logic v, input logic [7:0] d);
        start    = st;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(st, v, d);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_code(input string name, input logic [8*BYTES-1:0] exp_v);
        int first;
        tests++;
        if (code !== exp_v) begin
            fails++;
            first = -1;
            for (int i = BYTES - 1; i >= 0; i--) begin
                if (code[8*i +: 8] !== exp_v[8*i +: 8]) first = i;
            end
            $display("FAIL %s: code byte %0d got %0h expected %0h (t=%0t)",
                     name, first, code[8*first +: 8], exp_v[8*first +: 8], $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ctrl"}, {28'd0, in_ready, busy, done, cpu_reset},
            {28'd0, m_open, m_open, m_loaded, m_loaded});
        chk({tag, "_count"}, 32'(count), 32'(m_img.size()));
        chk_code({tag, "_code"}, model_code());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        e_ready;
        logic        e_done;
        int          e_count;
        logic [23:0] e_low;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic v, input logic [7:0] d,
                       input logic er, input logic ed, input int ec, input logic [23:0] el);
        vec_t r;
        r.st = st; r.v = v; r.d = d;
        r.e_ready = er; r.e_done = ed; r.e_count = ec; r.e_low = el;
        tbl.push_back(r);
    endtask

    logic [8*BYTES-1:0] exp_code;
    int                 cyc;
    int                 len;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();

        // Reset then idle: no start, loader stays quiet.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("idle_ctrl", {28'd0, in_ready, busy, done, cpu_reset}, 32'd0);
            chk_code("idle_code", '0);
        end
        chk("idle_count", 32'(count), 32'd0);

        // Basic load, then the same image with valid gaps 1,0,0,1,1,0,1.
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1, 24'h000001);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 2, 24'h000101);
        add(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 3, 24'h440101);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3, 24'h440101);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 0, 24'h000000);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1, 24'h000001);
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 2, 24'h000101);
        add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 2, 24'h000101);
        add(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 3, 24'h440101);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].d);
            chk("tbl_ready",  32'(in_ready),  32'(tbl[i].e_ready));
            chk("tbl_done",   32'(done),      32'(tbl[i].e_done));
            chk("tbl_cpurst", 32'(cpu_reset), 32'(tbl[i].e_done));
            chk("tbl_count",  32'(count),     32'(tbl[i].e_count));
            chk("tbl_low",    32'(code[23:0]), 32'(tbl[i].e_low));
        end
        exp_code = '0;
        exp_code[23:0] = 24'h440101;
        chk_code("tbl_full", exp_code);

        // Full 256-byte image, length byte 0.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        exp_code = '0;
        for (int k = 0; k < BYTES; k++) begin
            step(1'b0, 1'b1, 8'(k) ^ 8'hA5);
            exp_code[8*k +: 8] = 8'(k) ^ 8'hA5;
        end
        chk_code("full_code", exp_code);
        chk("full_count", 32'(count), 32'd256);
        chk("full_done", {30'd0, done, cpu_reset}, 32'd3);

        // Abort: start coincident with a valid byte drops that byte.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b1, 1'b1, 8'h33);
        chk_code("abort_code", '0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_ctrl", {28'd0, in_ready, busy, done, cpu_reset}, 32'hC);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h7E);
        exp_code = '0;
        exp_code[7:0] = 8'h7E;
        chk_code("abort_reload_code", exp_code);
        chk("abort_reload_done", {31'd0, done}, 32'd1);
        chk("abort_reload_count", 32'(count), 32'd1);

        // Asynchronous reset in the middle of a load.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h0A);
        step(1'b0, 1'b1, 8'hAB);
        step(1'b0, 1'b1, 8'hCD);
        start    = 1'b0;
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_ctrl", {28'd0, in_ready, busy, done, cpu_reset}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk_code("rst_code", '0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(1'b0, 1'b1, 8'h55);
        check_model("rst_after");

        // Reload from DONE: cpu_reset drops and the image clears.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'hA5);
        chk("reload_done", {30'd0, done, cpu_reset}, 32'd3);
        step(1'b1, 1'b0, 8'h00);
        chk("reload_cpurst", 32'(cpu_reset), 32'd0);
        chk("reload_ready", 32'(in_ready), 32'd1);
        chk_code("reload_code", '0);

        // Randomized loads with gaps and occasional aborts vs the model.
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, 40);
            step(1'b1, 1'b0, 8'h00);
            check_model("rnd_start");
            step(1'b0, 1'b1, 8'(len));
            check_model("rnd_len");
            cyc = 0;
            while (!done && cyc < 1500) begin
                step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                     8'($urandom));
                check_model("rnd_data");
                cyc++;
            end
            if (cyc >= 1500) begin
                tests++;
                fails++;
                $display("FAIL rnd_budget: done not seen within 1500 cycles (iteration %0d)", it);
            end
            for (int j = 0; j < 3; j++) begin
                step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
                check_model("rnd_hold");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
